// File: rtl/sdram_cmd_ctrl.sv
// sdram_cmd_ctrl - command-side controller for a x16, 4-bank, 13-bit-row,
// 10-bit-column SDR SDRAM with one host request port.
//
// Runs the power-up sequence (NOP wait, PRECHARGE all, two AUTO REFRESH,
// LOAD MODE REGISTER), periodic auto-refresh, and single-word closed-page
// reads and writes (ACT -> RD/WR -> PRE all).
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  host handshake; one request outstanding at a time
//   req_write            1 = write, 0 = read
//   req_addr             word address {ba[1], row[12:0], ba[0], col[9:0]}
//   req_wdata, req_be    write data and byte enables (1 = write the byte)
//   rdata, rdata_valid   read data, qualified by a one-cycle pulse
//   zs_*                 SDRAM pins; every output is registered, zs_dq is
//                        driven only in the WR cycle
//
// The FSM runs one cycle ahead of the pins: the command decoded from the
// current state is registered onto the pins at the next rising edge.
module sdram_cmd_ctrl #(
   parameter int CAS_LATENCY    = 3,
   parameter int INIT_WAIT      = 16,
   parameter int REFRESH_PERIOD = 780,
   parameter int T_RCD          = 2,
   parameter int T_RP           = 2,
   parameter int T_RFC          = 7,
   parameter int T_MRD          = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [24:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_be,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic [12:0] zs_addr,
   output logic [1:0]  zs_ba,
   output logic        zs_ras_n,
   output logic        zs_cas_n,
   output logic        zs_we_n,
   output logic        zs_cs_n,
   output logic        zs_cke,
   output logic [1:0]  zs_dqm,
   inout  wire  [15:0] zs_dq
);

   localparam int CNT_W = 16;
   localparam int REF_W = $clog2(REFRESH_PERIOD + 1);

   localparam logic [2:0] CMD_LMR = 3'b000;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_NOP = 3'b111;

   // Mode register: single-location write burst, CAS latency, sequential, BL=1.
   localparam logic [2:0]  CL_BITS  = 3'(CAS_LATENCY);
   localparam logic [12:0] LMR_MODE = {3'b000, 1'b1, 2'b00, CL_BITS, 1'b0, 3'b000};

   // Terminal counts. The *_NOP_LAST values are for waits entered from IDLE,
   // where the command cycle itself is issued by IDLE and is not counted.
   localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
   localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_WAIT - 1);
   localparam logic [CNT_W-1:0] RP_LAST      = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] RFC_LAST     = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] MRD_LAST     = CNT_W'(T_MRD - 1);
   localparam logic [CNT_W-1:0] CL_LAST      = CNT_W'(CAS_LATENCY - 1);
   localparam logic [CNT_W-1:0] RFC_NOP_LAST = CNT_W'(T_RFC - 2);
   localparam logic [CNT_W-1:0] RCD_NOP_LAST = CNT_W'(T_RCD - 2);
   localparam logic [REF_W-1:0] REF_LAST     = REF_W'(REFRESH_PERIOD - 1);

   typedef enum logic [3:0] {
      ST_INIT_WAIT,
      ST_INIT_PRE,
      ST_INIT_REF,
      ST_LMR,
      ST_IDLE,
      ST_REF,
      ST_RCD,
      ST_RW,
      ST_WR_NOP,
      ST_RD_WAIT,
      ST_PRE
   } state_t;

   state_t           state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic             ref2_r, ref2_nx_s;
   logic             ref_en_r, pend_r, pend_nx_s, pend_clr_s, wrap_s;
   logic [REF_W-1:0] ref_cnt_r;
   logic             ready_nx_s, accept_s, capture_s;
   logic             wr_r;
   logic [1:0]       ba_r;
   logic [9:0]       col_r;
   logic [15:0]      wdata_r;
   logic [1:0]       be_r;
   logic [2:0]       cmd_s;
   logic [12:0]      addr_s;
   logic [1:0]       ba_s;
   logic [1:0]       dqm_s;
   logic             dq_oe_s, dq_oe_r;
   logic [15:0]      dq_out_r;

   assign zs_dq = dq_oe_r ? dq_out_r : 16'hzzzz;

   // Next-state and next-pin decode for the command sequencer.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r + CNT_W'(1);
      ref2_nx_s  = ref2_r;
      cmd_s      = CMD_NOP;
      addr_s     = 13'd0;
      ba_s       = 2'd0;
      dqm_s      = 2'b11;
      dq_oe_s    = 1'b0;
      accept_s   = 1'b0;
      pend_clr_s = 1'b0;
      capture_s  = 1'b0;
      case (state_r)
         ST_INIT_WAIT: begin
            if (cnt_r == INIT_LAST) begin
               state_nx_s = ST_INIT_PRE;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_INIT_WAIT;
            end
         end
         ST_INIT_PRE: begin
            if (cnt_r == CNT_ZERO) begin
               cmd_s      = CMD_PRE;
               addr_s[10] = 1'b1;
            end else begin
               cmd_s = CMD_NOP;
            end
            if (cnt_r == RP_LAST) begin
               state_nx_s = ST_INIT_REF;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_INIT_PRE;
            end
         end
         ST_INIT_REF: begin
            if (cnt_r == CNT_ZERO) begin
               cmd_s = CMD_REF;
            end else begin
               cmd_s = CMD_NOP;
            end
            // ref2_r marks that the first of the two refreshes is done.
            if (cnt_r == RFC_LAST) begin
               cnt_nx_s = CNT_ZERO;
               if (ref2_r) begin
                  state_nx_s = ST_LMR;
                  ref2_nx_s  = 1'b0;
               end else begin
                  ref2_nx_s = 1'b1;
               end
            end else begin
               state_nx_s = ST_INIT_REF;
            end
         end
         ST_LMR: begin
            if (cnt_r == CNT_ZERO) begin
               cmd_s  = CMD_LMR;
               addr_s = LMR_MODE;
            end else begin
               cmd_s = CMD_NOP;
            end
            if (cnt_r == MRD_LAST) begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_LMR;
            end
         end
         ST_IDLE: begin
            // IDLE issues the first command of a sequence itself so that ACT
            // lands on the pins in the cycle right after the accept.
            cnt_nx_s = CNT_ZERO;
            if (pend_r) begin
               cmd_s = CMD_REF;
               if (T_RFC > 1) begin
                  state_nx_s = ST_REF;
               end else begin
                  pend_clr_s = 1'b1;
               end
            end else if (req_valid && req_ready) begin
               accept_s = 1'b1;
               cmd_s    = CMD_ACT;
               ba_s     = {req_addr[24], req_addr[10]};
               addr_s   = req_addr[23:11];
               if (T_RCD > 1) begin
                  state_nx_s = ST_RCD;
               end else begin
                  state_nx_s = ST_RW;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REF: begin
            if (cnt_r == RFC_NOP_LAST) begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = CNT_ZERO;
               pend_clr_s = 1'b1;
            end else begin
               state_nx_s = ST_REF;
            end
         end
         ST_RCD: begin
            if (cnt_r == RCD_NOP_LAST) begin
               state_nx_s = ST_RW;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_RCD;
            end
         end
         ST_RW: begin
            ba_s     = ba_r;
            addr_s   = {3'b000, col_r};
            cnt_nx_s = CNT_ZERO;
            if (wr_r) begin
               cmd_s      = CMD_WR;
               dqm_s      = ~be_r;
               dq_oe_s    = 1'b1;
               state_nx_s = ST_WR_NOP;
            end else begin
               cmd_s      = CMD_RD;
               dqm_s      = 2'b00;
               state_nx_s = ST_RD_WAIT;
            end
         end
         ST_WR_NOP: begin
            state_nx_s = ST_PRE;
            cnt_nx_s   = CNT_ZERO;
         end
         ST_RD_WAIT: begin
            if (cnt_r == CL_LAST) begin
               state_nx_s = ST_PRE;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_RD_WAIT;
            end
         end
         ST_PRE: begin
            // For a read, the PRE edge is also the edge that samples zs_dq
            // at the end of cycle RD+CAS_LATENCY.
            if (cnt_r == CNT_ZERO) begin
               cmd_s      = CMD_PRE;
               addr_s[10] = 1'b1;
               capture_s  = ~wr_r;
            end else begin
               cmd_s = CMD_NOP;
            end
            if (cnt_r == RP_LAST) begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_PRE;
            end
         end
         default: begin
            state_nx_s = ST_INIT_WAIT;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase
   end

   // Refresh request bookkeeping and the registered-ready decision.
   always_comb begin
      wrap_s     = ref_en_r && (ref_cnt_r == REF_LAST);
      pend_nx_s  = wrap_s || (pend_r && !pend_clr_s);
      ready_nx_s = (state_r == ST_IDLE) && (state_nx_s == ST_IDLE) && !pend_nx_s;
   end

   // Sequencer state, wait counter and init-refresh flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_INIT_WAIT;
         cnt_r   <= CNT_ZERO;
         ref2_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         ref2_r  <= ref2_nx_s;
      end
   end

   // Free-running refresh interval counter, enabled from the first IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_en_r  <= 1'b0;
         ref_cnt_r <= REF_W'(0);
         pend_r    <= 1'b0;
      end else begin
         ref_en_r <= ref_en_r | (state_r == ST_IDLE);
         pend_r   <= pend_nx_s;
         if (wrap_s) begin
            ref_cnt_r <= REF_W'(0);
         end else if (ref_en_r) begin
            ref_cnt_r <= ref_cnt_r + REF_W'(1);
         end else begin
            ref_cnt_r <= ref_cnt_r;
         end
      end
   end

   // Request latch on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_r    <= 1'b0;
         ba_r    <= 2'd0;
         col_r   <= 10'd0;
         wdata_r <= 16'd0;
         be_r    <= 2'd0;
      end else if (accept_s) begin
         wr_r    <= req_write;
         ba_r    <= {req_addr[24], req_addr[10]};
         col_r   <= req_addr[9:0];
         wdata_r <= req_wdata;
         be_r    <= req_be;
      end else begin
         wr_r    <= wr_r;
         ba_r    <= ba_r;
         col_r   <= col_r;
         wdata_r <= wdata_r;
         be_r    <= be_r;
      end
   end

   // Registered pins, host handshake and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zs_cke                         <= 1'b0;
         zs_cs_n                        <= 1'b1;
         {zs_ras_n, zs_cas_n, zs_we_n}  <= CMD_NOP;
         zs_addr                        <= 13'd0;
         zs_ba                          <= 2'd0;
         zs_dqm                         <= 2'b11;
         dq_oe_r                        <= 1'b0;
         dq_out_r                       <= 16'd0;
         req_ready                      <= 1'b0;
         rdata                          <= 16'd0;
         rdata_valid                    <= 1'b0;
      end else begin
         zs_cke                         <= 1'b1;
         zs_cs_n                        <= 1'b0;
         {zs_ras_n, zs_cas_n, zs_we_n}  <= cmd_s;
         zs_addr                        <= addr_s;
         zs_ba                          <= ba_s;
         zs_dqm                         <= dqm_s;
         dq_oe_r                        <= dq_oe_s;
         dq_out_r                       <= wdata_r;
         req_ready                      <= ready_nx_s;
         rdata_valid                    <= capture_s;
         if (capture_s) begin
            rdata <= zs_dq;
         end else begin
            rdata <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_sdram_cmd_ctrl.sv
// tb_sdram_cmd_ctrl - directed self-checking bench for sdram_cmd_ctrl.
// A small SDRAM model decodes the pins (ACT row per bank, masked WR, RD data
// returned CAS_LATENCY cycles later); directed tasks check command timing,
// addresses, masks and read data against hand-computed values.
module tb_sdram_cmd_ctrl;

   localparam int CL     = 3;
   localparam int INIT_W = 16;
   localparam int RP     = 780;
   localparam int T_RCD  = 2;
   localparam int T_RFC  = 7;
   localparam int T_RP   = 2;

   localparam logic [2:0] C_LMR = 3'b000;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_NOP = 3'b111;

   localparam logic [24:0] A1 = 25'h1ABCDEF;  // ba=11 row=1579 col=1EF
   localparam logic [24:0] A2 = 25'h0012345;  // ba=00 row=0024 col=345

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid, req_write;
   logic [24:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        req_ready, rdata_valid;
   logic [15:0] rdata;
   logic [12:0] zs_addr;
   logic [1:0]  zs_ba, zs_dqm;
   logic        zs_ras_n, zs_cas_n, zs_we_n, zs_cs_n, zs_cke;
   wire  [15:0] zs_dq;

   logic        mdl_oe = 1'b0;
   logic [15:0] mdl_dq = 16'h0000;
   assign zs_dq = mdl_oe ? mdl_dq : 16'hzzzz;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int cs_viol = 0;

   wire [2:0] cmd = {zs_ras_n, zs_cas_n, zs_we_n};

   sdram_cmd_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rdata(rdata), .rdata_valid(rdata_valid),
      .zs_addr(zs_addr), .zs_ba(zs_ba), .zs_ras_n(zs_ras_n), .zs_cas_n(zs_cas_n),
      .zs_we_n(zs_we_n), .zs_cs_n(zs_cs_n), .zs_cke(zs_cke), .zs_dqm(zs_dqm),
      .zs_dq(zs_dq)
   );

   always #5 clk = ~clk;

   // Cycle counter used by the SDRAM model to time read data.
   always @(posedge clk) cyc <= cyc + 1;

   // SDRAM model: decode pins mid-cycle, store masked writes, return reads.
   logic [12:0] open_row [4];
   logic [15:0] mem [256];
   int          rd_due = -100;
   int          rd_key = 0;

   function automatic int mkey(input logic [1:0] b, input logic [12:0] r, input logic [9:0] c);
      return int'({b, r[2:0], c[2:0]});
   endfunction

   always @(negedge clk) begin
      if (zs_cke && zs_cs_n) cs_viol <= cs_viol + 1;
      if (cyc == rd_due) begin
         mdl_oe <= 1'b1;
         mdl_dq <= mem[rd_key];
      end else begin
         mdl_oe <= 1'b0;
      end
      if (zs_cke && !zs_cs_n) begin
         case (cmd)
            C_ACT: open_row[zs_ba] <= zs_addr;
            C_WR: begin
               if (!zs_dqm[1]) mem[mkey(zs_ba, open_row[zs_ba], zs_addr[9:0])][15:8] <= zs_dq[15:8];
               if (!zs_dqm[0]) mem[mkey(zs_ba, open_row[zs_ba], zs_addr[9:0])][7:0]  <= zs_dq[7:0];
            end
            C_RD: begin
               rd_due <= cyc + CL;
               rd_key <= mkey(zs_ba, open_row[zs_ba], zs_addr[9:0]);
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic skip_nops(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (cmd != C_NOP || zs_dqm != 2'b11) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check(tag, 32'(req_ready), 32'd1);
   endtask

   task automatic check_init();
      int n_nop = 0;
      for (int i = 0; i < INIT_W; i++) begin
         @(negedge clk);
         if (zs_cke && !zs_cs_n && cmd == C_NOP) n_nop++;
      end
      check("init_nop_cycles", n_nop, INIT_W);
      @(negedge clk);
      check("init_pre", cmd, C_PRE);
      check("init_pre_a10", zs_addr[10], 1'b1);
      skip_nops("init_trp", T_RP - 1);
      @(negedge clk);
      check("init_ref1", cmd, C_REF);
      skip_nops("init_trfc1", T_RFC - 1);
      @(negedge clk);
      check("init_ref2", cmd, C_REF);
      skip_nops("init_trfc2", T_RFC - 1);
      @(negedge clk);
      check("init_lmr", cmd, C_LMR);
      check("lmr_addr", zs_addr, 13'h230);
      check("lmr_ba", zs_ba, 2'b00);
      @(negedge clk);
      check("ready_lmr_p1", req_ready, 1'b0);
      @(negedge clk);
      check("ready_lmr_p2", req_ready, 1'b1);
   endtask

   task automatic do_write(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be,
                           input logic [1:0] e_ba, input logic [12:0] e_row,
                           input logic [9:0] e_col, input logic [1:0] e_dqm);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      wait_ready("wr_ready_timeout");
      @(negedge clk);
      req_valid = 1'b0;
      check("wr_act", cmd, C_ACT);
      check("wr_act_ba", zs_ba, e_ba);
      check("wr_act_row", zs_addr, e_row);
      check("wr_ready_drop", req_ready, 1'b0);
      skip_nops("wr_trcd", T_RCD - 1);
      @(negedge clk);
      check("wr_cmd", cmd, C_WR);
      check("wr_col", zs_addr, {3'b000, e_col});
      check("wr_dqm", zs_dqm, e_dqm);
      check("wr_dq", zs_dq, d);
      skip_nops("wr_nop", 1);
      @(negedge clk);
      check("wr_pre", cmd, C_PRE);
      check("wr_pre_a10", zs_addr[10], 1'b1);
   endtask

   task automatic do_read(input logic [24:0] a, input logic [15:0] e_data,
                          input logic [1:0] e_ba, input logic [12:0] e_row, input logic [9:0] e_col);
      int lat = 0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      wait_ready("rd_ready_timeout");
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_act", cmd, C_ACT);
      check("rd_act_ba", zs_ba, e_ba);
      check("rd_act_row", zs_addr, e_row);
      skip_nops("rd_trcd", T_RCD - 1);
      @(negedge clk);
      check("rd_cmd", cmd, C_RD);
      check("rd_col", zs_addr, {3'b000, e_col});
      check("rd_dqm", zs_dqm, 2'b00);
      while (lat < 16) begin
         @(negedge clk);
         lat++;
         if (rdata_valid) break;
      end
      check("rd_latency", lat, CL + 1);
      check("rd_data", rdata, e_data);
      check("rd_pre", cmd, C_PRE);
      @(negedge clk);
      check("rd_pulse", rdata_valid, 1'b0);
   endtask

   initial begin
      int n;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 25'd0; req_wdata = 16'd0; req_be = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_cke", zs_cke, 1'b0);
      check("rst_cs_n", zs_cs_n, 1'b1);
      check("rst_cmd", cmd, C_NOP);
      check("rst_addr", zs_addr, 13'd0);
      check("rst_ba", zs_ba, 2'd0);
      check("rst_dqm", zs_dqm, 2'b11);
      check("rst_ready", req_ready, 1'b0);
      check("rst_rdata", rdata, 16'd0);
      check("rst_valid", rdata_valid, 1'b0);
      reset = 1'b0;
      check_init();

      do_write(A1, 16'hBEEF, 2'b11, 2'b11, 13'h1579, 10'h1EF, 2'b00);
      do_read(A1, 16'hBEEF, 2'b11, 13'h1579, 10'h1EF);
      do_write(A2, 16'h1234, 2'b11, 2'b00, 13'h0024, 10'h345, 2'b00);
      do_write(A2, 16'hAB00, 2'b10, 2'b00, 13'h0024, 10'h345, 2'b01);
      do_read(A2, 16'hAB34, 2'b00, 13'h0024, 10'h345);
      repeat (3) @(negedge clk);
      check("rdata_hold", rdata, 16'hAB34);

      // Refresh priority: raise a read exactly as ready drops for refresh.
      wait_ready("ref_idle_timeout");
      n = 0;
      while (req_ready && n < RP + 50) begin
         @(negedge clk);
         n++;
      end
      check("ref_ready_fall", req_ready, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = A1;
      @(negedge clk);
      check("ref_cmd", cmd, C_REF);
      n = 0;
      while (!req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("ref_ready_low", n, T_RFC);
      do_read(A1, 16'hBEEF, 2'b11, 13'h1579, 10'h1EF);

      // Reset between ACT and RD.
      req_valid = 1'b1; req_write = 1'b0; req_addr = A2;
      wait_ready("mid_ready_timeout");
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_act", cmd, C_ACT);
      reset = 1'b1;
      #1;
      check("mid_rst_cke", zs_cke, 1'b0);
      check("mid_rst_cs_n", zs_cs_n, 1'b1);
      check("mid_rst_cmd", cmd, C_NOP);
      check("mid_rst_dqm", zs_dqm, 2'b11);
      check("mid_rst_ready", req_ready, 1'b0);
      check("mid_rst_rdata", rdata, 16'd0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rdata_valid || cmd != C_NOP) n++;
      end
      check("mid_quiet", n, 0);
      reset = 1'b0;
      check_init();
      do_read(A2, 16'hAB34, 2'b00, 13'h0024, 10'h345);

      check("cs_with_cke", cs_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
